nrzi_stuff_codec: RTL and testbench

Parametrised NRZI line codec with integrated bit stuffing/unstuffing. It is the successor to the plain single-bit NRZI encoder/decoder pair. The transmit half turns a handshaked serial bit stream into an NRZI line level with a registered output enable; the receive half decodes a sampled line, removes stuffed bits and flags stuffing violations. It sits between the packet serialiser/deserialiser and the bus pad logic.

---
 rtl/nrzi_stuff_codec.sv | 148 ++++++++++++++
 tb/tb_nrzi_stuff_codec.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nrzi_stuff_codec.sv
// NRZI line codec: transmit encoder with registered enable, receive decoder with unstuffing.
// Define NRZI_STUFF_EN to build bit stuffing/unstuffing; leave it undefined for plain NRZI.
module nrzi_stuff_codec #(
  parameter int   STUFF_LEN = 6,
  parameter logic IDLE_LVL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_valid,
  input  logic tx_bit,
  output logic tx_ready,
  output logic tx_line,
  output logic tx_oe,
  input  logic rx_en,
  input  logic rx_line,
  output logic rx_valid,
  output logic rx_bit,
  output logic rx_stuff_err
);

  logic r_tx_line;
  logic r_tx_oe;
  logic r_rx_prev;
  logic r_rx_valid;
  logic r_rx_bit;
  logic r_rx_err;
  logic w_rx_d;

  // A decoded 1 is an unchanged line level between consecutive samples.
  assign w_rx_d = (rx_line == r_rx_prev);

`ifdef NRZI_STUFF_EN
  localparam int               CNT_W   = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STUFF_LEN);

  logic [CNT_W-1:0] r_tx_cnt;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [CNT_W-1:0] w_tx_cnt_inc;
  logic [CNT_W-1:0] w_rx_cnt_inc;
  logic             r_stuff_pend;

  assign w_tx_cnt_inc = r_tx_cnt + CNT_W'(1);
  assign w_rx_cnt_inc = r_rx_cnt + CNT_W'(1);
  assign tx_ready     = ~rst & ~r_stuff_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_line    <= IDLE_LVL;
      r_tx_oe      <= 1'b0;
      r_tx_cnt     <= '0;
      r_stuff_pend <= 1'b0;
    end else if (r_stuff_pend) begin
      // Stuffed zero goes out even if the packet has already ended.
      r_tx_line    <= ~r_tx_line;
      r_tx_oe      <= 1'b1;
      r_tx_cnt     <= '0;
      r_stuff_pend <= 1'b0;
    end else if (tx_valid) begin
      r_tx_oe <= 1'b1;
      if (tx_bit) begin
        r_tx_cnt <= w_tx_cnt_inc;
        if (w_tx_cnt_inc == CNT_MAX) begin
          r_stuff_pend <= 1'b1;
        end
      end else begin
        r_tx_line <= ~r_tx_line;
        r_tx_cnt  <= '0;
      end
    end else begin
      r_tx_line <= IDLE_LVL;
      r_tx_oe   <= 1'b0;
      r_tx_cnt  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_prev  <= IDLE_LVL;
      r_rx_cnt   <= '0;
      r_rx_valid <= 1'b0;
      r_rx_bit   <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_err <= 1'b0;
      if (!rx_en) begin
        r_rx_prev  <= IDLE_LVL;
        r_rx_cnt   <= '0;
        r_rx_valid <= 1'b0;
      end else begin
        r_rx_prev <= rx_line;
        if (r_rx_cnt != CNT_MAX) begin
          r_rx_valid <= 1'b1;
          r_rx_bit   <= w_rx_d;
          r_rx_cnt   <= w_rx_d ? w_rx_cnt_inc : '0;
        end else begin
          // This position must hold a stuffed zero; a one here is a violation.
          r_rx_valid <= 1'b0;
          r_rx_cnt   <= '0;
          r_rx_err   <= w_rx_d;
        end
      end
    end
  end
`else
  assign tx_ready = ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_line <= IDLE_LVL;
      r_tx_oe   <= 1'b0;
    end else if (tx_valid) begin
      r_tx_oe <= 1'b1;
      if (!tx_bit) begin
        r_tx_line <= ~r_tx_line;
      end
    end else begin
      r_tx_line <= IDLE_LVL;
      r_tx_oe   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_prev  <= IDLE_LVL;
      r_rx_valid <= 1'b0;
      r_rx_bit   <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_err <= 1'b0;
      if (!rx_en) begin
        r_rx_prev  <= IDLE_LVL;
        r_rx_valid <= 1'b0;
      end else begin
        r_rx_prev  <= rx_line;
        r_rx_valid <= 1'b1;
        r_rx_bit   <= w_rx_d;
      end
    end
  end
`endif

  assign tx_line      = r_tx_line;
  assign tx_oe        = r_tx_oe;
  assign rx_valid     = r_rx_valid;
  assign rx_bit       = r_rx_bit;
  assign rx_stuff_err = r_rx_err;

endmodule

// File: tb/tb_nrzi_stuff_codec.sv
// Self-checking bench for nrzi_stuff_codec (STUFF_LEN=6, IDLE_LVL=1), with or without NRZI_STUFF_EN.
module tb_nrzi_stuff_codec;
  localparam int   STUFF_LEN = 6;
  localparam logic IDLE_LVL  = 1'b1;
`ifdef NRZI_STUFF_EN
  localparam bit STUFF_ON = 1'b1;
`else
  localparam bit STUFF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_valid = 1'b0;
  logic tx_bit = 1'b0;
  logic rx_en_drv = 1'b0;
  logic rx_line_drv = 1'b1;
  logic loopback = 1'b0;
  logic tx_ready, tx_line, tx_oe, rx_valid, rx_bit, rx_stuff_err;
  logic rx_en, rx_line;

  assign rx_en   = loopback ? tx_oe   : rx_en_drv;
  assign rx_line = loopback ? tx_line : rx_line_drv;

  nrzi_stuff_codec #(.STUFF_LEN(STUFF_LEN), .IDLE_LVL(IDLE_LVL)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_bit(tx_bit), .tx_ready(tx_ready),
    .tx_line(tx_line), .tx_oe(tx_oe),
    .rx_en(rx_en), .rx_line(rx_line),
    .rx_valid(rx_valid), .rx_bit(rx_bit), .rx_stuff_err(rx_stuff_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int last_bubbles = 0;
  int last_oe = 0;
  logic txl_q[$];
  logic txo_q[$];
  logic rxq[$];
  bit   pkt[$];

  typedef struct {
    logic rst, tv, tb, re, rl;
    logic el, eo, er, ev, eb, ee;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    txl_q.push_back(tx_line);
    txo_q.push_back(tx_oe);
    if (rx_valid) rxq.push_back(rx_bit);
    if (rx_stuff_err) err_cnt++;
  endtask

  // Send pkt with handshaking, compare line/oe against a stuffed-NRZI model and the loopback receive stream.
  task automatic send_packet(input string nm);
    bit   stuffed[$];
    logic lv[$];
    logic lvl;
    int   run;
    int   bubbles;
    bit   tmo;
    logic rdy;
    int   w;
    bubbles = 0;
    tmo = 1'b0;
    loopback = 1'b1;
    tx_valid = 1'b0;
    repeat (2) tick();
    txl_q.delete(); txo_q.delete(); rxq.delete(); err_cnt = 0;
    foreach (pkt[i]) begin
      tx_valid = 1'b1;
      tx_bit = pkt[i];
      w = 0;
      do begin
        rdy = tx_ready;
        if (!rdy) bubbles++;
        tick();
        w++;
      end while (!rdy && w < 8);
      if (!rdy) tmo = 1'b1;
    end
    tx_valid = 1'b0;
    tx_bit = 1'b0;
    repeat (4) tick();
    run = 0;
    foreach (pkt[i]) begin
      stuffed.push_back(pkt[i]);
      run = pkt[i] ? run + 1 : 0;
      if (STUFF_ON && run == STUFF_LEN) begin
        stuffed.push_back(1'b0);
        run = 0;
      end
    end
    lvl = IDLE_LVL;
    foreach (stuffed[i]) begin
      if (!stuffed[i]) lvl = ~lvl;
      lv.push_back(lvl);
    end
    chk({nm, " handshake_timeout"}, int'(tmo), 0);
    last_oe = 0;
    foreach (txl_q[i]) begin
      chk($sformatf("%s tx_line[%0d]", nm, i), int'(txl_q[i]), int'(i < lv.size() ? lv[i] : IDLE_LVL));
      chk($sformatf("%s tx_oe[%0d]", nm, i), int'(txo_q[i]), int'(i < lv.size()));
      if (txo_q[i] === 1'b1) last_oe++;
    end
    chk({nm, " rx_count"}, rxq.size(), pkt.size());
    foreach (pkt[i]) begin
      if (i < rxq.size()) chk($sformatf("%s rx_bit[%0d]", nm, i), int'(rxq[i]), int'(pkt[i]));
    end
    chk({nm, " rx_stuff_err"}, err_cnt, 0);
    last_bubbles = bubbles;
    loopback = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst tv tb re rl   el eo er ev eb ee
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      rst = tbl[i].rst; tx_valid = tbl[i].tv; tx_bit = tbl[i].tb;
      rx_en_drv = tbl[i].re; rx_line_drv = tbl[i].rl;
      tick();
      chk($sformatf("vec%0d tx_line", i), int'(tx_line), int'(tbl[i].el));
      chk($sformatf("vec%0d tx_oe", i), int'(tx_oe), int'(tbl[i].eo));
      chk($sformatf("vec%0d tx_ready", i), int'(tx_ready), int'(tbl[i].er));
      chk($sformatf("vec%0d rx_valid", i), int'(rx_valid), int'(tbl[i].ev));
      chk($sformatf("vec%0d rx_bit", i), int'(rx_bit), int'(tbl[i].eb));
      chk($sformatf("vec%0d rx_stuff_err", i), int'(rx_stuff_err), int'(tbl[i].ee));
    end

    // Eight ones: one stuff bubble and nine driven cycles when stuffing is built.
    pkt.delete();
    repeat (8) pkt.push_back(1'b1);
    send_packet("ones8");
    chk("ones8 bubbles", last_bubbles, STUFF_ON ? 1 : 0);
    chk("ones8 driven_cycles", last_oe, STUFF_ON ? 9 : 8);

    // Random loopback stream biased towards long runs of ones.
    pkt.delete();
    for (int i = 0; i < 200; i++) pkt.push_back($urandom_range(0, 3) != 0);
    send_packet("rand200");

    // Receive: a toggle, then seven unchanged samples, then a toggle.
    rx_en_drv = 1'b0;
    rx_line_drv = 1'b1;
    repeat (2) tick();
    rx_en_drv = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic ev, eb, ee;
      rx_line_drv = (i == 8) ? 1'b1 : 1'b0;
      tick();
      ev = 1'b1; eb = 1'b1; ee = 1'b0;
      if (i == 0 || i == 8) eb = 1'b0;
      if (i == 7 && STUFF_ON) begin ev = 1'b0; ee = 1'b1; end
      chk($sformatf("viol%0d rx_valid", i), int'(rx_valid), int'(ev));
      if (ev) chk($sformatf("viol%0d rx_bit", i), int'(rx_bit), int'(eb));
      chk($sformatf("viol%0d rx_stuff_err", i), int'(rx_stuff_err), int'(ee));
    end
    rx_en_drv = 1'b0;
    tick();
    chk("rx_en_fall rx_valid", int'(rx_valid), 0);
    chk("rx_en_fall rx_stuff_err", int'(rx_stuff_err), 0);

    // Reset while a stuff is pending.
    tick();
    for (int i = 0; i < STUFF_LEN; i++) begin
      tx_valid = 1'b1; tx_bit = 1'b1;
      tick();
    end
    chk("pend tx_ready", int'(tx_ready), STUFF_ON ? 0 : 1);
    chk("pend tx_line", int'(tx_line), 1);
    rst = 1'b1; tx_valid = 1'b0; tx_bit = 1'b0;
    tick();
    chk("rstpend tx_line", int'(tx_line), int'(IDLE_LVL));
    chk("rstpend tx_oe", int'(tx_oe), 0);
    chk("rstpend tx_ready", int'(tx_ready), 0);
    rst = 1'b0;
    tick();
    chk("rstrel tx_line", int'(tx_line), int'(IDLE_LVL));
    chk("rstrel tx_oe", int'(tx_oe), 0);
    chk("rstrel tx_ready", int'(tx_ready), 1);

    pkt.delete();
    repeat (6) pkt.push_back(1'b1);
    pkt.push_back(1'b0);
    pkt.push_back(1'b1);
    send_packet("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
